// File: rtl/elbeth_definitions.sv
// Shared exception codes and arbiter state encoding for the elbeth memory path.
package elbeth_definitions;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IACC = 2'd1,
      ST_DACC = 2'd2,
      ST_RESP = 2'd3
   } arb_state_t;

   // RISC-V mcause exception codes used by the memory arbiter
   localparam logic [3:0] ECODE_INST_ADDR_MISALIGNED      = 4'd0;
   localparam logic [3:0] ECODE_INST_ADDR_FAULT           = 4'd1;
   localparam logic [3:0] ECODE_LOAD_ADDR_MISALIGNED      = 4'd4;
   localparam logic [3:0] ECODE_LOAD_ACCESS_FAULT         = 4'd5;
   localparam logic [3:0] ECODE_STORE_AMO_ADDR_MISALIGNED = 4'd6;
   localparam logic [3:0] ECODE_STORE_AMO_ACCESS_FAULT    = 4'd7;

endpackage

// File: rtl/elbeth_timeout_counter.sv
// Wait-cycle counter; expired flags the wait cycle whose increment reaches TIMEOUT.
module elbeth_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_reg;

   assign expired = enable && (count_reg == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != CNT_W'(TIMEOUT))) begin
         count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data ports.
module elbeth_mem_arbiter
   import elbeth_definitions::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  imem_en,
   input  logic [31:0]           imem_addr,
   output logic [DATA_WIDTH-1:0] imem_in_data,
   output logic                  imem_ready,
   output logic                  imem_except,
   output logic [3:0]            imem_except_src,
   input  logic                  dmem_en,
   input  logic [31:0]           dmem_addr,
   input  logic [DATA_WIDTH-1:0] dmem_out_data,
   input  logic [3:0]            dmem_rw,
   output logic [DATA_WIDTH-1:0] dmem_in_data,
   output logic                  dmem_ready,
   output logic                  dmem_except,
   output logic [3:0]            dmem_except_src,
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_out_data,
   output logic [3:0]            mem_rw,
   input  logic [DATA_WIDTH-1:0] mem_in_data,
   input  logic                  mem_ready,
   input  logic                  mem_error
);

   arb_state_t            state_reg;
   logic                  last_data_reg;
   logic                  mem_en_reg;
   logic [ADDR_WIDTH-1:0] mem_addr_reg;
   logic [DATA_WIDTH-1:0] mem_wdata_reg;
   logic [3:0]            mem_rw_reg;
   logic [DATA_WIDTH-1:0] imem_data_reg;
   logic                  imem_ready_reg;
   logic                  imem_except_reg;
   logic [3:0]            imem_src_reg;
   logic [DATA_WIDTH-1:0] dmem_data_reg;
   logic                  dmem_ready_reg;
   logic                  dmem_except_reg;
   logic [3:0]            dmem_src_reg;

   logic        grant_any;
   logic        grant_data;
   logic [31:0] req_addr;
   logic        misaligned;
   logic        out_of_range;
   logic        req_store;
   logic [3:0]  early_code;
   logic        in_acc;
   logic        acc_done;
   logic        acc_ok;
   logic        expired;
   logic [3:0]  dfault_code;

   // Data wins a tie unless it was the last port served
   assign grant_any    = imem_en || dmem_en;
   assign grant_data   = dmem_en && (!imem_en || !last_data_reg);
   assign req_addr     = grant_data ? dmem_addr : imem_addr;
   assign misaligned   = |req_addr[1:0];
   assign out_of_range = |req_addr[31:ADDR_WIDTH+2];
   assign req_store    = |dmem_rw;

   always_comb begin
      early_code = '0;
      if (!grant_data) begin
         early_code = misaligned ? ECODE_INST_ADDR_MISALIGNED : ECODE_INST_ADDR_FAULT;
      end else if (req_store) begin
         early_code = misaligned ? ECODE_STORE_AMO_ADDR_MISALIGNED : ECODE_STORE_AMO_ACCESS_FAULT;
      end else begin
         early_code = misaligned ? ECODE_LOAD_ADDR_MISALIGNED : ECODE_LOAD_ACCESS_FAULT;
      end
   end

   assign in_acc      = (state_reg == ST_IACC) || (state_reg == ST_DACC);
   assign acc_ok      = mem_ready && !mem_error;
   assign acc_done    = mem_error || mem_ready || expired;
   assign dfault_code = (|mem_rw_reg) ? ECODE_STORE_AMO_ACCESS_FAULT : ECODE_LOAD_ACCESS_FAULT;

   elbeth_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_acc),
      .enable  (in_acc && !mem_ready && !mem_error),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         last_data_reg   <= 1'b0;
         mem_en_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         mem_rw_reg      <= '0;
         imem_data_reg   <= '0;
         imem_ready_reg  <= 1'b0;
         imem_except_reg <= 1'b0;
         imem_src_reg    <= '0;
         dmem_data_reg   <= '0;
         dmem_ready_reg  <= 1'b0;
         dmem_except_reg <= 1'b0;
         dmem_src_reg    <= '0;
      end else begin
         imem_ready_reg  <= 1'b0;
         imem_except_reg <= 1'b0;
         dmem_ready_reg  <= 1'b0;
         dmem_except_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (grant_any) begin
                  last_data_reg <= grant_data;
                  if (misaligned || out_of_range) begin
                     state_reg <= ST_RESP;
                     if (grant_data) begin
                        dmem_except_reg <= 1'b1;
                        dmem_src_reg    <= early_code;
                     end else begin
                        imem_except_reg <= 1'b1;
                        imem_src_reg    <= early_code;
                     end
                  end else begin
                     state_reg     <= grant_data ? ST_DACC : ST_IACC;
                     mem_en_reg    <= 1'b1;
                     mem_addr_reg  <= req_addr[ADDR_WIDTH+1:2];
                     mem_rw_reg    <= grant_data ? dmem_rw : 4'b0000;
                     mem_wdata_reg <= grant_data ? dmem_out_data : '0;
                  end
               end
            end
            ST_IACC, ST_DACC: begin
               if (acc_done) begin
                  state_reg     <= ST_RESP;
                  mem_en_reg    <= 1'b0;
                  mem_rw_reg    <= '0;
                  mem_wdata_reg <= '0;
                  if (state_reg == ST_IACC) begin
                     if (acc_ok) begin
                        imem_ready_reg <= 1'b1;
                        imem_data_reg  <= mem_in_data;
                     end else begin
                        imem_except_reg <= 1'b1;
                        imem_src_reg    <= ECODE_INST_ADDR_FAULT;
                     end
                  end else begin
                     if (acc_ok) begin
                        dmem_ready_reg <= 1'b1;
                        dmem_data_reg  <= mem_in_data;
                     end else begin
                        dmem_except_reg <= 1'b1;
                        dmem_src_reg    <= dfault_code;
                     end
                  end
               end
            end
            ST_RESP: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign mem_en          = mem_en_reg;
   assign mem_addr        = mem_addr_reg;
   assign mem_out_data    = mem_wdata_reg;
   assign mem_rw          = mem_rw_reg;
   assign imem_in_data    = imem_data_reg;
   assign imem_ready      = imem_ready_reg;
   assign imem_except     = imem_except_reg;
   assign imem_except_src = imem_src_reg;
   assign dmem_in_data    = dmem_data_reg;
   assign dmem_ready      = dmem_ready_reg;
   assign dmem_except     = dmem_except_reg;
   assign dmem_except_src = dmem_src_reg;

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench for elbeth_mem_arbiter with a zero-wait memory model and forced error/stall modes.
module tb_elbeth_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_en = 1'b0;
   logic [31:0] imem_addr = '0;
   logic [31:0] imem_in_data;
   logic        imem_ready;
   logic        imem_except;
   logic [3:0]  imem_except_src;
   logic        dmem_en = 1'b0;
   logic [31:0] dmem_addr = '0;
   logic [31:0] dmem_out_data = '0;
   logic [3:0]  dmem_rw = '0;
   logic [31:0] dmem_in_data;
   logic        dmem_ready;
   logic        dmem_except;
   logic [3:0]  dmem_except_src;
   logic        mem_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_out_data;
   logic [3:0]  mem_rw;
   logic [31:0] mem_in_data;
   logic        mem_ready;
   logic        mem_error;

   logic        auto_ready = 1'b1;
   logic        err_force = 1'b0;
   logic [31:0] mem_words [256];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          men_cnt = 0;
   logic [7:0]  last_addr = '0;
   logic [3:0]  last_rw = '0;
   logic [31:0] last_wd = '0;

   always #5 clk = ~clk;

   assign mem_ready   = auto_ready && mem_en;
   assign mem_error   = err_force && mem_en;
   assign mem_in_data = mem_words[mem_addr];

   elbeth_mem_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_en         (imem_en),
      .imem_addr       (imem_addr),
      .imem_in_data    (imem_in_data),
      .imem_ready      (imem_ready),
      .imem_except     (imem_except),
      .imem_except_src (imem_except_src),
      .dmem_en         (dmem_en),
      .dmem_addr       (dmem_addr),
      .dmem_out_data   (dmem_out_data),
      .dmem_rw         (dmem_rw),
      .dmem_in_data    (dmem_in_data),
      .dmem_ready      (dmem_ready),
      .dmem_except     (dmem_except),
      .dmem_except_src (dmem_except_src),
      .mem_en          (mem_en),
      .mem_addr        (mem_addr),
      .mem_out_data    (mem_out_data),
      .mem_rw          (mem_rw),
      .mem_in_data     (mem_in_data),
      .mem_ready       (mem_ready),
      .mem_error       (mem_error)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         men_cnt   <= men_cnt + 1;
         last_addr <= mem_addr;
         last_rw   <= mem_rw;
         last_wd   <= mem_out_data;
         if (mem_ready && !mem_error) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_rw[b]) mem_words[mem_addr][8*b +: 8] <= mem_out_data[8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Runs one request to completion; lat counts edges from the request cycle to the response cycle.
   task automatic xfer(input bit is_d, input logic [31:0] addr, input logic [3:0] rw,
                       input logic [31:0] wd, output int lat, output logic exc,
                       output logic [3:0] src, output logic [31:0] rdata, output int men);
      int men0;
      @(posedge clk); #1;
      men0 = men_cnt;
      if (is_d) begin
         dmem_en = 1'b1; dmem_addr = addr; dmem_rw = rw; dmem_out_data = wd;
      end else begin
         imem_en = 1'b1; imem_addr = addr;
      end
      lat = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         lat++;
         if (is_d ? (dmem_ready || dmem_except) : (imem_ready || imem_except)) break;
      end
      exc   = is_d ? dmem_except : imem_except;
      src   = is_d ? dmem_except_src : imem_except_src;
      rdata = is_d ? dmem_in_data : imem_in_data;
      imem_en = 1'b0;
      dmem_en = 1'b0;
      men = men_cnt - men0;
      $display("xfer %s addr=0x%08h rw=%b lat=%0d exc=%0b src=%0d rdata=0x%08h mem_en_cycles=%0d",
               is_d ? "D" : "I", addr, rw, lat, exc, src, rdata, men);
   endtask

   initial begin
      int          lat;
      int          men;
      logic        exc;
      logic [3:0]  src;
      logic [31:0] rd;
      int          order [4];
      int          nord;
      int          got;
      int          dr_seen;

      for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
      mem_words[4]  = 32'hDEADBEEF;
      mem_words[8]  = 32'hCAFEF00D;
      mem_words[16] = 32'h11223344;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_outs", {imem_ready, imem_except, dmem_ready, dmem_except, imem_except_src, dmem_except_src}, 32'd0);
      chk("rst_idata", imem_in_data, 32'd0);
      rst_n = 1'b1;

      // Basic fetch
      xfer(1'b0, 32'h10, 4'h0, 32'h0, lat, exc, src, rd, men);
      chk("fetch_lat", lat, 32'd2);
      chk("fetch_exc", {31'd0, exc}, 32'd0);
      chk("fetch_data", rd, 32'hDEADBEEF);
      chk("fetch_addr", {24'd0, last_addr}, 32'h04);
      chk("fetch_rw", {28'd0, last_rw}, 32'd0);
      chk("fetch_men", men, 32'd1);

      // Both ports requesting, twice
      nord = 0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         imem_en = 1'b1; imem_addr = 32'h10;
         dmem_en = 1'b1; dmem_addr = 32'h20; dmem_rw = 4'h0;
         got = 0;
         for (int c = 0; c < 40 && got < 2; c++) begin
            @(posedge clk); #1;
            if (dmem_ready && nord < 4) begin order[nord] = 1; nord++; dmem_en = 1'b0; got++; end
            if (imem_ready && nord < 4) begin order[nord] = 0; nord++; imem_en = 1'b0; got++; end
         end
         imem_en = 1'b0; dmem_en = 1'b0;
      end
      $display("grant order count=%0d", nord);
      chk("both_count", nord, 32'd4);
      chk("grant0_d", order[0], 32'd1);
      chk("grant1_i", order[1], 32'd0);
      chk("grant2_d", order[2], 32'd1);
      chk("grant3_i", order[3], 32'd0);
      chk("both_ddata", dmem_in_data, 32'hCAFEF00D);

      // Misaligned store
      xfer(1'b1, 32'h22, 4'b1111, 32'h12345678, lat, exc, src, rd, men);
      chk("smis_lat", lat, 32'd1);
      chk("smis_exc", {31'd0, exc}, 32'd1);
      chk("smis_src", {28'd0, src}, 32'd6);
      chk("smis_men", men, 32'd0);
      chk("smis_hold", rd, 32'hCAFEF00D);

      // Out-of-range load
      xfer(1'b1, 32'h400, 4'h0, 32'h0, lat, exc, src, rd, men);
      chk("lrng_lat", lat, 32'd1);
      chk("lrng_src", {28'd0, src}, 32'd5);
      chk("lrng_men", men, 32'd0);

      // Misaligned fetch
      xfer(1'b0, 32'h13, 4'h0, 32'h0, lat, exc, src, rd, men);
      chk("imis_src", {28'd0, src}, 32'd0);
      chk("imis_exc", {31'd0, exc}, 32'd1);

      // Load timeout
      auto_ready = 1'b0;
      xfer(1'b1, 32'h40, 4'h0, 32'h0, lat, exc, src, rd, men);
      auto_ready = 1'b1;
      chk("tmo_lat", lat, 32'd16);
      chk("tmo_men", men, 32'd15);
      chk("tmo_src", {28'd0, src}, 32'd5);
      chk("tmo_exc", {31'd0, exc}, 32'd1);

      // Memory error on fetch keeps old fetched word
      err_force = 1'b1;
      xfer(1'b0, 32'h20, 4'h0, 32'h0, lat, exc, src, rd, men);
      err_force = 1'b0;
      chk("ierr_lat", lat, 32'd2);
      chk("ierr_src", {28'd0, src}, 32'd1);
      chk("ierr_hold", rd, 32'hDEADBEEF);

      // Partial store then load back
      xfer(1'b1, 32'h40, 4'b0011, 32'hA5A5A5A5, lat, exc, src, rd, men);
      chk("st_lat", lat, 32'd2);
      chk("st_exc", {31'd0, exc}, 32'd0);
      chk("st_rw", {28'd0, last_rw}, 32'b0011);
      chk("st_wd", last_wd, 32'hA5A5A5A5);
      xfer(1'b1, 32'h40, 4'h0, 32'h0, lat, exc, src, rd, men);
      chk("ld_data", rd, 32'h1122A5A5);
      chk("ld_addr", {24'd0, last_addr}, 32'h10);
      chk("ihold", imem_in_data, 32'hDEADBEEF);

      // Reset during a data access
      auto_ready = 1'b0;
      @(posedge clk); #1;
      dmem_en = 1'b1; dmem_addr = 32'h80; dmem_rw = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pre_men", {31'd0, mem_en}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_async_men", {31'd0, mem_en}, 32'd0);
      chk("rst_ddata", dmem_in_data, 32'd0);
      auto_ready = 1'b1;
      dr_seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (dmem_ready || dmem_except) dr_seen++;
      end
      dmem_en = 1'b0;
      rst_n = 1'b1;
      chk("rst_no_resp", dr_seen, 32'd0);
      xfer(1'b1, 32'h40, 4'h0, 32'h0, lat, exc, src, rd, men);
      chk("post_rst_lat", lat, 32'd2);
      chk("post_rst_data", rd, 32'h1122A5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
